// File: rtl/chan_dump.sv
// Streams the whole capture RAM to the UART, oldest sample first, one byte per tx_done handshake.
// Define CHAN_DUMP_HDR_EN to prefix each dump with a 0xA5 header byte.
module chan_dump #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump,
    input  logic [LOG2-1:0] waddr,
    output logic            ren,
    output logic [LOG2-1:0] raddr,
    input  logic [7:0]      rdata,
    output logic [7:0]      tx_data,
    output logic            trmt,
    input  logic            tx_done,
    output logic            busy,
    output logic            dump_done
);

    typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, WAIT_TX} state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    state_t          state;
    logic [LOG2-1:0] cnt;
`ifdef CHAN_DUMP_HDR_EN
    logic            hdr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            raddr     <= '0;
            cnt       <= '0;
            tx_data   <= '0;
            ren       <= 1'b0;
            trmt      <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
`ifdef CHAN_DUMP_HDR_EN
            hdr       <= 1'b0;
`endif
        end else begin
            ren       <= 1'b0;
            trmt      <= 1'b0;
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A request coinciding with the completion pulse belongs to the old dump.
                    if (dump && !dump_done) begin
                        raddr <= waddr;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef CHAN_DUMP_HDR_EN
                        hdr     <= 1'b1;
                        tx_data <= 8'hA5;
                        trmt    <= 1'b1;
                        state   <= SEND;
`else
                        ren   <= 1'b1;
                        state <= RD;
`endif
                    end
                end
                RD: state <= LATCH;
                LATCH: begin
                    tx_data <= rdata;
                    trmt    <= 1'b1;
                    state   <= SEND;
                end
                SEND: state <= WAIT_TX;
                WAIT_TX: begin
                    if (tx_done) begin
`ifdef CHAN_DUMP_HDR_EN
                        if (hdr) begin
                            hdr   <= 1'b0;
                            ren   <= 1'b1;
                            state <= RD;
                        end else
`endif
                        if (cnt == LAST) begin
                            dump_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            raddr <= (raddr == LAST) ? '0 : raddr + 1'b1;
                            cnt   <= cnt + 1'b1;
                            ren   <= 1'b1;
                            state <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_dump.sv
module tb_chan_dump;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
`ifdef CHAN_DUMP_HDR_EN
    localparam int NHDR = 1;
`else
    localparam int NHDR = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            dump;
    logic [LOG2-1:0] waddr;
    logic            ren;
    logic [LOG2-1:0] raddr;
    logic [7:0]      rdata;
    logic [7:0]      tx_data;
    logic            trmt;
    logic            tx_done;
    logic            busy;
    logic            dump_done;
    logic            auto_done;
    logic            stray_done;

    int checks = 0;
    int errors = 0;

    int        n_trmt, n_ren, n_done, n_oob, n_busy_fall;
    logic      prev_busy = 1'b0;
    logic [7:0] bytes[$];
    int        addrs[$];
    logic [7:0] mem [ENTRIES];

    chan_dump #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .dump      (dump),
        .waddr     (waddr),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .tx_done   (tx_done),
        .busy      (busy),
        .dump_done (dump_done)
    );

    always #5 clk = ~clk;

    assign tx_done = auto_done | stray_done;

    initial begin
        for (int i = 0; i < ENTRIES; i++) mem[i] = i[7:0];
    end

    always @(posedge clk) if (ren) rdata <= mem[raddr];

    // UART stand-in: completion pulse 10 cycles after each strobe.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt) begin
                repeat (10) @(negedge clk);
                auto_done = 1'b1;
                @(negedge clk);
                auto_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (trmt) begin
            n_trmt++;
            bytes.push_back(tx_data);
        end
        if (ren) begin
            n_ren++;
            addrs.push_back(int'(raddr));
            if (raddr >= LOG2'(ENTRIES)) n_oob++;
        end
        if (dump_done) n_done++;
        if (prev_busy && !busy) n_busy_fall++;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_trmt = 0; n_ren = 0; n_done = 0; n_oob = 0; n_busy_fall = 0;
        bytes.delete();
        addrs.delete();
    endtask

    // Accept a dump, then poke waddr and a stray tx_done while the first read is in flight.
    task automatic start_dump(input int wa);
        clear_stats();
        waddr = LOG2'(wa);
        dump  = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_ren", ren, (NHDR == 0) ? 1 : 0);
        waddr      = LOG2'((wa + 55) % ENTRIES);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (dump_done) break;
        end
        check("done_seen", dump_done, 1);
        // A request in the completion cycle must not start another dump.
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        repeat (3) @(negedge clk);
        check("no_restart_busy", busy, 0);
    endtask

    task automatic check_dump(input int wa);
        int bad_b, bad_a, e;
        logic [7:0] eb;
        bad_b = 0;
        bad_a = 0;
        check("trmt_count", n_trmt, ENTRIES + NHDR);
        check("ren_count", n_ren, ENTRIES);
        check("done_count", n_done, 1);
        check("busy_fall", n_busy_fall, 1);
        check("raddr_oob", n_oob, 0);
        for (int k = 0; k < bytes.size(); k++) begin
            if (k < NHDR) eb = 8'hA5;
            else begin
                e  = (wa + k - NHDR) % ENTRIES;
                eb = e[7:0];
            end
            if (bytes[k] !== eb) bad_b++;
        end
        for (int k = 0; k < addrs.size(); k++)
            if (addrs[k] != (wa + k) % ENTRIES) bad_a++;
        check("byte_seq", bad_b, 0);
        check("raddr_seq", bad_a, 0);
        check("first_raddr", (addrs.size() > 0) ? addrs[0] : -1, wa);
        check("last_raddr", (addrs.size() > 0) ? addrs[addrs.size()-1] : -1,
              (wa + ENTRIES - 1) % ENTRIES);
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        dump       = 1'b0;
        waddr      = '0;
        stray_done = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_outputs", {ren, trmt, busy, dump_done, raddr, tx_data}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Stray completion while idle
        waddr      = 9'd33;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_stray_raddr", raddr, 0);
        check("idle_stray_trmt", n_trmt, 0);

        // Full dump from 0 with a re-request at byte 50
        start_dump(0);
        for (k = 0; k < 2000 && n_trmt < 50; k++) @(negedge clk);
        check("reach_byte50", (n_trmt >= 50) ? 1 : 0, 1);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        wait_done(8000);
        check_dump(0);
`ifdef CHAN_DUMP_HDR_EN
        check("hdr_first", (bytes.size() > 1) ? bytes[0] : 8'h00, 8'hA5);
        check("hdr_second", (bytes.size() > 1) ? bytes[1] : 8'hFF, 8'h00);
`endif

        // Wrapping dump
        start_dump(100);
        wait_done(8000);
        check_dump(100);

        // Abort by reset while waiting on byte 200
        start_dump(0);
        for (k = 0; k < 5000 && n_trmt < 200; k++) @(negedge clk);
        check("reach_byte200", (n_trmt >= 200) ? 1 : 0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {ren, trmt, busy, dump_done, raddr, tx_data}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", n_done, 0);
        check("abort_idle", busy, 0);

        start_dump(7);
        wait_done(8000);
        check_dump(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
